// File: rtl/column_slice_sequencer_if.sv
// Signal bundle between the column sequencer, the slice-height calculator and the VGA plot port.
// master = sequencer side, slave = environment (frame trigger, calculator, framebuffer writer).
interface column_slice_sequencer_if;
    logic       start_frame;
    logic [6:0] slice_size;
    logic       end_calc;
    logic [7:0] column_count;
    logic       begin_calc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;
    logic       timeout_seen;

    modport master (
        input  start_frame, slice_size, end_calc,
        output column_count, begin_calc, x, y, colour, plot, busy, frame_done, timeout_seen
    );

    modport slave (
        output start_frame, slice_size, end_calc,
        input  column_count, begin_calc, x, y, colour, plot, busy, frame_done, timeout_seen
    );
endinterface

// File: rtl/column_slice_sequencer.sv
// Walks screen columns, requests a slice height per column and rasterises ceiling/wall/floor pixels.
// Latency: first plot 2 cycles after end_calc; no backpressure, the plot port must accept one pixel per cycle.
module column_slice_sequencer #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter int          CALC_TIMEOUT = 255,
    parameter logic [2:0]  CEIL_COLOUR  = 3'b001,
    parameter logic [2:0]  WALL_COLOUR  = 3'b111,
    parameter logic [2:0]  FLOOR_COLOUR = 3'b010
) (
    input  logic                      clock,
    input  logic                      reset,
    column_slice_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START_CALC, S_WAIT_CALC, S_LATCH, S_DRAW, S_NEXT_COL, S_DONE
    } state_t;

    localparam int            CW       = $clog2(CALC_TIMEOUT + 1);
    localparam logic [7:0]    COL_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0]    ROW_LAST = 7'(SCREEN_H - 1);
    localparam logic [6:0]    ROWS     = 7'(SCREEN_H);
    localparam logic [6:0]    MID      = 7'(SCREEN_H / 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(CALC_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      column_count_q, column_count_d;
    logic [6:0]      h_raw_q, h_raw_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;
    logic            begin_calc_q, begin_calc_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            timeout_seen_q, timeout_seen_d;

    // Span bounds derive from the held raw height, so they are already valid for y=0 at the LATCH edge.
    logic [6:0] h_clamp, top, bot;
    assign h_clamp = (h_raw_q > ROWS) ? ROWS : h_raw_q;
    assign top     = MID - {1'b0, h_clamp[6:1]};
    assign bot     = top + h_clamp;

    always_comb begin
        state_d        = state_q;
        column_count_d = column_count_q;
        h_raw_d        = h_raw_q;
        cnt_d          = cnt_q;
        y_d            = y_q;
        timeout_seen_d = timeout_seen_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_frame) begin
                    state_d        = S_START_CALC;
                    column_count_d = 8'd0;
                    timeout_seen_d = 1'b0;
                end
            end
            S_START_CALC: begin
                cnt_d   = '0;
                state_d = S_WAIT_CALC;
            end
            S_WAIT_CALC: begin
                if (bus.end_calc) begin
                    h_raw_d = bus.slice_size;
                    state_d = S_LATCH;
                end else if (cnt_q == TMO_LAST) begin
                    h_raw_d        = 7'd0;
                    timeout_seen_d = 1'b1;
                    state_d        = S_LATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                y_d     = 7'd0;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (y_q == ROW_LAST) begin
                    state_d = S_NEXT_COL;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
            S_NEXT_COL: begin
                if (column_count_q == COL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    column_count_d = column_count_q + 1'b1;
                    state_d        = S_START_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        begin_calc_d = (state_d == S_START_CALC);
        plot_d       = (state_d == S_DRAW);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        colour_d     = 3'b000;
        if (state_d == S_DRAW) begin
            if (y_d < top)      colour_d = CEIL_COLOUR;
            else if (y_d < bot) colour_d = WALL_COLOUR;
            else                colour_d = FLOOR_COLOUR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            column_count_q <= 8'd0;
            h_raw_q        <= 7'd0;
            cnt_q          <= '0;
            y_q            <= 7'd0;
            colour_q       <= 3'b000;
            plot_q         <= 1'b0;
            begin_calc_q   <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            timeout_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            column_count_q <= column_count_d;
            h_raw_q        <= h_raw_d;
            cnt_q          <= cnt_d;
            y_q            <= y_d;
            colour_q       <= colour_d;
            plot_q         <= plot_d;
            begin_calc_q   <= begin_calc_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end

    assign bus.column_count = column_count_q;
    assign bus.x            = column_count_q;
    assign bus.y            = y_q;
    assign bus.colour       = colour_q;
    assign bus.plot         = plot_q;
    assign bus.begin_calc   = begin_calc_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.timeout_seen = timeout_seen_q;
endmodule

// File: doc/column_slice_sequencer.md
# column_slice_sequencer

Frame-level initiator for the raycaster slice pipeline. It walks the screen columns in order and, for each column, drives `column_count` and a one-cycle `begin_calc` into the slice-height calculator. It then waits for `end_calc`, captures `slice_size`, and rasterises that column as ceiling, wall and floor pixels on the VGA adapter's plot interface. It sits between the frame trigger (game-loop control) and the framebuffer writer.

## Interface
Parameters:
- SCREEN_W, 160, number of columns per frame (column_count runs 0..SCREEN_W-1)
- SCREEN_H, 120, number of rows per column (y runs 0..SCREEN_H-1)
- CALC_TIMEOUT, 255, maximum cycles to wait for end_calc before forcing height 0
- CEIL_COLOUR, 3'b001, colour for pixels above the wall span
- WALL_COLOUR, 3'b111, colour for pixels inside the wall span
- FLOOR_COLOUR, 3'b010, colour for pixels below the wall span

Ports:
- clock  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start_frame  in  1  one-cycle request to render a full frame
- slice_size  in  7  slice height from the calculator, valid when end_calc=1
- end_calc  in  1  calculator completion pulse
- column_count  out  8  current column index sent to the calculator
- begin_calc  out  1  one-cycle start pulse to the calculator
- x  out  8  plot x (equals column_count)
- y  out  7  plot y
- colour  out  3  plot colour
- plot  out  1  pixel write enable
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel of column SCREEN_W-1
- timeout_seen  out  1  sticky per frame; set if any column timed out

## Operation
- States: IDLE, START_CALC, WAIT_CALC, LATCH, DRAW, NEXT_COL, DONE.
- IDLE: busy=0. If start_frame=1, go to START_CALC: clear column_count to 0 and clear timeout_seen.
- START_CALC (1 cycle): begin_calc=1. Clear the timeout counter. Go to WAIT_CALC.
- WAIT_CALC: end_calc is sampled only in this state.
  - end_calc=1: capture slice_size into h_raw, go to LATCH.
  - Counter reaches CALC_TIMEOUT first: h_raw=0, set timeout_seen, go to LATCH.
- LATCH (1 cycle): h = min(h_raw, SCREEN_H). top = SCREEN_H/2 − (h>>1), computed as unsigned 7-bit. bot = top + h (exclusive). Set y=0. Go to DRAW.
- DRAW: plot=1 for exactly SCREEN_H cycles, y = 0..SCREEN_H-1, x = column_count. Colour selection:
  - y < top: CEIL_COLOUR
  - top ≤ y < bot: WALL_COLOUR
  - y ≥ bot: FLOOR_COLOUR
  - h=0 means top=bot=60, so no wall pixels are drawn.
  - After y=SCREEN_H-1, go to NEXT_COL.
- NEXT_COL (1 cycle): if column_count = SCREEN_W-1, go to DONE. Otherwise increment column_count and go to START_CALC.
- DONE (1 cycle): frame_done=1, go to IDLE. timeout_seen holds until the next frame is accepted.
- start_frame outside IDLE is ignored and not queued.
- column_count is held stable from START_CALC through LATCH; the calculator relies on this.
- An end_calc pulse arriving in any state other than WAIT_CALC is ignored.

## Timing
- Reset values: state=IDLE, column_count=0, x=0, y=0, colour=0, plot=0, begin_calc=0, busy=0, frame_done=0, timeout_seen=0. Reset mid-frame aborts immediately; no further plot or begin_calc follows.
- All outputs are registered.
- begin_calc rises on the cycle after start_frame is sampled, or on the cycle after NEXT_COL.
- end_calc sampled at cycle k of WAIT_CALC gives the first plot at cycle k+2 (LATCH sits between them).
- Cycles per column = 1 (START) + W (wait, ≥1) + 1 (LATCH) + SCREEN_H + 1 (NEXT).
- Timeout: a wait of CALC_TIMEOUT cycles with no end_calc forces exit on that cycle.
- A frame with a fixed wait W takes SCREEN_W·(SCREEN_H+3+W) cycles, plus 1 for DONE.

## Test plan
- Reset, then start_frame with a responder returning slice_size=40 after 3 cycles → per column: begin_calc once, y0–39 ceiling, y40–79 wall, y80–119 floor; 160 columns; frame_done once; timeout_seen=0.
- slice_size=127 (clamped to 120) and slice_size=0 → all 120 pixels wall, and all pixels ceiling(0–59)/floor(60–119) respectively.
- slice_size=41 (odd) → top=40, bot=81, wall y40–80.
- Responder never asserts end_calc for column 5 → column 5 exits WAIT after 255 cycles and draws with h=0; timeout_seen=1 at frame_done; other columns unaffected.
- start_frame pulsed during DRAW, and a spurious end_calc during DRAW → both ignored; column sequence and pixel count unchanged.
- Reset asserted mid-DRAW of column 80 → next cycle all outputs at reset values; a new start_frame restarts at column 0.
